// File: rtl/part_one_sqrt.sv
`default_nettype none
// ============================================================================
//  Module   : part_one_sqrt
//  Purpose  : Pipelined 8-bit square root, y = floor(sqrt(x * 256)) in Q4.4,
//             restoring digit-by-digit, one root bit per stage, 8 stages.
//  Revision : 1.0  initial release
// ============================================================================
module part_one_sqrt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] x,
    output logic [7:0] y
);

    localparam int unsigned C_STAGES = 8;

    // Stage k registers feed the combinational step k; step 7 writes r_root[8].
    logic [15:0] r_rad  [0:C_STAGES-1];
    logic [9:0]  r_rem  [0:C_STAGES-1];
    logic [7:0]  r_root [0:C_STAGES];
    logic        r_vld  [0:C_STAGES-1];

    // Entry register: radicand is x scaled by 256 to produce 4 fraction bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rad[0]  <= '0;
            r_rem[0]  <= '0;
            r_root[0] <= '0;
            r_vld[0]  <= 1'b0;
        end else begin
            r_rad[0]  <= {x, 8'h00};
            r_rem[0]  <= '0;
            r_root[0] <= '0;
            r_vld[0]  <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < C_STAGES; gi = gi + 1) begin : g_stage
            logic [9:0] w_rem_sh;
            logic [9:0] w_trial;
            logic [9:0] w_diff;
            logic       w_ge;
            logic [9:0] w_rem_nxt;
            logic [7:0] w_root_nxt;

            // The remainder entering stage k never exceeds 2*(2^k - 1) <= 254,
            // so its low 8 bits plus the next radicand pair fit in 10 bits.
            assign w_rem_sh   = {r_rem[gi][7:0], r_rad[gi][15:14]};
            assign w_trial    = {r_root[gi], 2'b01};
            assign w_diff     = w_rem_sh - w_trial;
            assign w_ge       = (w_rem_sh >= w_trial);
            assign w_rem_nxt  = w_ge ? w_diff : w_rem_sh;
            assign w_root_nxt = {r_root[gi][6:0], w_ge};

            // Invalid slots propagate a zero root so y reads 0 until real data.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_root[gi+1] <= '0;
                end else if (r_vld[gi]) begin
                    r_root[gi+1] <= w_root_nxt;
                end else begin
                    r_root[gi+1] <= '0;
                end
            end

            if (gi < C_STAGES - 1) begin : g_carry
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_rad[gi+1] <= '0;
                        r_rem[gi+1] <= '0;
                        r_vld[gi+1] <= 1'b0;
                    end else begin
                        r_rad[gi+1] <= {r_rad[gi][13:0], 2'b00};
                        r_rem[gi+1] <= w_rem_nxt;
                        r_vld[gi+1] <= r_vld[gi];
                    end
                end
            end
        end
    endgenerate

    assign y = r_root[C_STAGES];

endmodule
`default_nettype wire

// File: tb/tb_part_one_sqrt.sv
`default_nettype none
// ============================================================================
//  Module   : tb_part_one_sqrt
//  Purpose  : Scoreboard bench for part_one_sqrt against floor(sqrt(x*256)).
//  Revision : 1.0  initial release
// ============================================================================
module tb_part_one_sqrt;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] x;
    logic [7:0] y;

    part_one_sqrt dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .y     (y)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] exp;
    } item_t;

    item_t sb[$];
    int    cyc    = 0;
    int    errors = 0;
    int    checks = 0;
    bit    done   = 1'b0;

    // Largest q with q*q <= x*256, found by plain search.
    function automatic logic [7:0] ref_sqrt(input logic [7:0] v);
        int r;
        int q;
        r = int'(v) * 256;
        q = 0;
        while (q < 255 && (q + 1) * (q + 1) <= r) q++;
        return q[7:0];
    endfunction

    // Every non-reset edge issues a sample due 8 edges later; reset drops all.
    always @(posedge clk) begin
        cyc++;
        if (rst_n !== 1'b1) sb.delete();
        else                sb.push_back('{cyc + 8, ref_sqrt(x)});
    end

    initial begin : monitor
        item_t      it;
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (done) break;
            while (sb.size() > 0 && sb[0].due < cyc) begin
                it = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL stale_sample cycle=%0d due=%0d expected=%h never seen", cyc, it.due, it.exp);
            end
            e = 8'h00;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                it = sb.pop_front();
                e  = it.exp;
            end
            checks++;
            if (y !== e) begin
                errors++;
                $display("FAIL y_check cycle=%0d got=%h expected=%h", cyc, y, e);
            end
        end
    end

    task automatic step(input logic [7:0] xv, input logic rv);
        @(negedge clk);
        x     = xv;
        rst_n = rv;
    endtask

    initial begin : driver
        logic [7:0] corners [0:3];
        logic [7:0] stream  [0:5];
        corners = '{8'h01, 8'h02, 8'h40, 8'hFF};
        stream  = '{8'h00, 8'h01, 8'h04, 8'h10, 8'hAB, 8'hFF};

        rst_n = 1'b0;
        x     = 8'hAB;
        repeat (2) step(8'hAB, 1'b0);
        checks++;
        if (y !== 8'h00) begin
            errors++;
            $display("FAIL reset_y got=%h expected=00", y);
        end

        repeat (8) step(8'h00, 1'b1);
        checks++;
        if (y !== 8'h00) begin
            errors++;
            $display("FAIL post_release_y got=%h expected=00", y);
        end
        step(8'hAB, 1'b1);
        repeat (9) step(8'h00, 1'b1);
        checks++;
        if (y !== 8'hD1) begin
            errors++;
            $display("FAIL latency_ab got=%h expected=d1", y);
        end
        step(8'h00, 1'b1);

        for (int i = 0; i < 4; i++) begin
            step(corners[i], 1'b1);
            repeat (3) step(8'h00, 1'b1);
        end
        repeat (8) step(8'h00, 1'b1);

        for (int i = 0; i < 6; i++) step(stream[i], 1'b1);
        repeat (20) step(8'($urandom_range(0, 255)), 1'b1);

        repeat (4) step(8'($urandom_range(1, 255)), 1'b1);
        step(8'($urandom_range(0, 255)), 1'b0);
        repeat (12) step(8'($urandom_range(0, 255)), 1'b1);

        for (int i = 0; i < 256; i++) step(i[7:0], 1'b1);
        repeat (40) step(8'($urandom_range(0, 255)), 1'b1);
        repeat (10) step(8'h00, 1'b1);
        checks++;
        if (y !== 8'h00) begin
            errors++;
            $display("FAIL final_zero got=%h expected=00", y);
        end

        done = 1'b1;
        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
